seg7_digit_driver: RTL and testbench

//   Segment-side driver for the multiplexed 8-digit 7-segment display. It consumes the
//   one-hot digit select from the scan counter and emits the digit anode enables plus the

---
 rtl/seg7_digit_driver.sv | 240 ++++++++++++++++++++++++
 tb/tb_seg7_digit_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_digit_driver.sv
// -----------------------------------------------------------------------------
// seg7_digit_driver
//   Segment-side driver for a multiplexed 8-digit 7-segment display. Takes the
//   one-hot digit select from the scan counter and produces registered anode
//   enables plus the decoded segment byte for the active digit. Display data
//   is written through a valid/ready port into a pending buffer and only
//   becomes visible at a frame boundary (select entering digit 7). A short
//   dead time with all anodes off follows every select change to avoid ghosting.
//
// Ports
//   clk_div   in   1   scan clock (same clock as the scan counter)
//   rst_n     in   1   asynchronous active-low reset
//   en        in   1   display enable
//   select    in   8   one-hot digit select, bit i = digit i, 0 = no digit
//   wr_valid  in   1   write request
//   wr_ready  out  1   write accept (high while no write is pending)
//   wr_data   in   32  hex nibbles, wr_data[4i+3:4i] is digit i
//   wr_dp     in   8   decimal point per digit
//   lz_en     in   1   leading-zero suppression, used live
//   seg       out  8   {dp,g,f,e,d,c,b,a}, registered
//   dig_an    out  8   digit anode enables (active-high), registered
//   err       out  1   sticky flag: select seen with more than one bit set
// -----------------------------------------------------------------------------
module seg7_digit_driver #(
    parameter int unsigned BLANK_CYC      = 1,
    parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
    input  logic        clk_div,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  select,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    input  logic        lz_en,
    output logic [7:0]  seg,
    output logic [7:0]  dig_an,
    output logic        err
);

    localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYC);
    localparam logic [7:0] SEG_OFF    = ACTIVE_LOW_SEG ? 8'hFF : 8'h00;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } wr_state_e;

    // Active-high g..a pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    wr_state_e   state_q, state_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [7:0]  pend_dp_q, pend_dp_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic [7:0]  disp_dp_q, disp_dp_d;
    logic [7:0]  sel_q, sel_d;
    logic [3:0]  blank_cnt_q, blank_cnt_d;
    logic [7:0]  seg_q, seg_d;
    logic [7:0]  dig_an_q, dig_an_d;
    logic        err_q, err_d;

    logic        frame_bnd_s;
    logic        sel_chg_s;
    logic        multi_s;
    logic        one_hot_s;
    logic [2:0]  dig_idx_s;
    logic [3:0]  nib_s;
    logic [7:0]  lz_mask_s;
    logic        suppress_s;
    logic [7:0]  raw_seg_s;
    logic        blank_s;

    // Write FSM state register.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM next state: accept in IDLE, release to IDLE at a frame boundary or when disabled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_valid) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (frame_bnd_s || !en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write FSM outputs.
    always_comb begin
        wr_ready = 1'b0;
        case (state_q)
            ST_IDLE: wr_ready = 1'b1;
            ST_PEND: wr_ready = 1'b0;
            default: wr_ready = 1'b0;
        endcase
    end

    // Select qualification: change detect, frame boundary, one-hot checks.
    always_comb begin
        sel_chg_s   = (select != sel_q);
        frame_bnd_s = (select == 8'h80) && (sel_q != 8'h80);
        multi_s     = ((select & (select - 8'd1)) != 8'd0);
        one_hot_s   = (select != 8'd0) && !multi_s;
    end

    // Buffer updates: capture into pend on accept, copy pend to disp on release.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        if ((state_q == ST_IDLE) && wr_valid) begin
            pend_data_d = wr_data;
            pend_dp_d   = wr_dp;
        end else if ((state_q == ST_PEND) && (frame_bnd_s || !en)) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
        end else begin
            pend_data_d = pend_data_q;
            disp_data_d = disp_data_q;
        end
    end

    // Dead-time counter reloads on every select change and counts down otherwise.
    always_comb begin
        sel_d = select;
        if (sel_chg_s) begin
            blank_cnt_d = BLANK_INIT;
        end else if (blank_cnt_q != 4'd0) begin
            blank_cnt_d = blank_cnt_q - 4'd1;
        end else begin
            blank_cnt_d = blank_cnt_q;
        end
    end

    // Active digit index and leading-zero mask (bit i set when nibbles 7..i are zero).
    always_comb begin
        logic zero_above;
        dig_idx_s  = 3'd0;
        lz_mask_s  = 8'd0;
        zero_above = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (select[i]) begin
                dig_idx_s = 3'(i);
            end else begin
                dig_idx_s = dig_idx_s;
            end
        end
        for (int i = 7; i >= 0; i--) begin
            zero_above   = zero_above && (disp_data_q[i*4 +: 4] == 4'd0);
            lz_mask_s[i] = zero_above;
        end
        nib_s      = disp_data_q[{dig_idx_s, 2'b00} +: 4];
        suppress_s = lz_en && (dig_idx_s != 3'd0) && lz_mask_s[dig_idx_s];
    end

    // Next output byte; digit suppression keeps the anode and dp, only g..a go dark.
    always_comb begin
        blank_s   = (sel_chg_s && (BLANK_CYC != 0)) || (blank_cnt_q > 4'd1);
        raw_seg_s = {disp_dp_q[dig_idx_s], suppress_s ? 7'h00 : hex_decode(nib_s)};
        err_d     = err_q || multi_s;
        if (!en || !one_hot_s || blank_s) begin
            dig_an_d = 8'h00;
            seg_d    = SEG_OFF;
        end else begin
            dig_an_d = select;
            seg_d    = ACTIVE_LOW_SEG ? ~raw_seg_s : raw_seg_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_q <= 32'd0;
            pend_dp_q   <= 8'd0;
            disp_data_q <= 32'd0;
            disp_dp_q   <= 8'd0;
            sel_q       <= 8'd0;
            blank_cnt_q <= 4'd0;
            seg_q       <= SEG_OFF;
            dig_an_q    <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            sel_q       <= sel_d;
            blank_cnt_q <= blank_cnt_d;
            seg_q       <= seg_d;
            dig_an_q    <= dig_an_d;
            err_q       <= err_d;
        end
    end

    assign seg    = seg_q;
    assign dig_an = dig_an_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seg7_digit_driver.sv
module tb_seg7_digit_driver;

    logic        clk_div;
    logic        rst_n;
    logic        en;
    logic [7:0]  select;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [7:0]  wr_dp;
    logic        lz_en;
    logic [7:0]  seg;
    logic [7:0]  dig_an;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    seg7_digit_driver #(.BLANK_CYC(1), .ACTIVE_LOW_SEG(1'b1)) dut (
        .clk_div  (clk_div),
        .rst_n    (rst_n),
        .en       (en),
        .select   (select),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_dp    (wr_dp),
        .lz_en    (lz_en),
        .seg      (seg),
        .dig_an   (dig_an),
        .err      (err)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    // Move select to a digit: one dead cycle, then lit with the expected byte.
    task automatic scan_digit(input logic [7:0] sel, input logic [7:0] exp_seg);
        select = sel;
        tick();
        check_eq($sformatf("blank_%h", sel), {24'd0, dig_an}, 32'h00);
        tick();
        check_eq($sformatf("an_%h", sel), {24'd0, dig_an}, {24'd0, sel});
        check_eq($sformatf("seg_%h", sel), {24'd0, seg}, {24'd0, exp_seg});
        tick();
        tick();
        check_eq($sformatf("hold_%h", sel), {24'd0, dig_an}, {24'd0, sel});
    endtask

    task automatic write_word(input logic [31:0] d, input logic [7:0] dp);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = dp;
        tick();
        check_eq("wr_acc_busy", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b0;
    endtask

    logic [7:0] sel_tab [8];
    logic [7:0] seg_tab [8];

    initial begin
        sel_tab = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

        // 1: reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en       = 1'($urandom);
            select   = 8'($urandom);
            wr_valid = 1'($urandom);
            wr_data  = $urandom;
            wr_dp    = 8'($urandom);
            lz_en    = 1'($urandom);
            tick();
        end
        check_eq("rst_seg", {24'd0, seg}, 32'hFF);
        check_eq("rst_an", {24'd0, dig_an}, 32'h00);
        check_eq("rst_ready", {31'd0, wr_ready}, 32'd1);
        check_eq("rst_err", {31'd0, err}, 32'd0);

        en = 1'b0; select = 8'h00; wr_valid = 1'b0; wr_data = 32'd0; wr_dp = 8'd0; lz_en = 1'b0;
        rst_n = 1'b1;
        tick();
        select = 8'h01;
        tick();
        tick();
        check_eq("rel_en0_an", {24'd0, dig_an}, 32'h00);
        check_eq("rel_en0_seg", {24'd0, seg}, 32'hFF);
        en = 1'b1;
        select = 8'h00;
        tick();
        tick();
        check_eq("rel_sel0_an", {24'd0, dig_an}, 32'h00);

        // 2: basic image and rotation
        write_word(32'h0123_4567, 8'h00);
        for (int i = 0; i < 8; i++) begin
            scan_digit(sel_tab[i], seg_tab[i]);
        end
        check_eq("rot_ready", {31'd0, wr_ready}, 32'd1);

        // 3: write mid-frame, second write stalls until the first is applied
        write_word(32'h89AB_CDEF, 8'h00);
        wr_valid = 1'b1;
        wr_data  = 32'h2EDC_BA98;
        wr_dp    = 8'h00;
        tick();
        check_eq("stall_ready", {31'd0, wr_ready}, 32'd0);
        select = 8'h02;
        tick();
        tick();
        check_eq("old_img_seg", {24'd0, seg}, 32'h82);
        check_eq("old_img_ready", {31'd0, wr_ready}, 32'd0);
        select = 8'h80;
        tick();
        check_eq("bnd_ready", {31'd0, wr_ready}, 32'd1);
        check_eq("bnd_an", {24'd0, dig_an}, 32'h00);
        tick();
        check_eq("b_accepted", {31'd0, wr_ready}, 32'd0);
        check_eq("a_d7_seg", {24'd0, seg}, 32'h80);
        wr_valid = 1'b0;
        scan_digit(8'h01, 8'h8E);
        check_eq("b_pend", {31'd0, wr_ready}, 32'd0);
        scan_digit(8'h80, 8'hA4);
        scan_digit(8'h01, 8'h80);

        // 4: leading-zero suppression
        lz_en = 1'b1;
        write_word(32'h0000_0040, 8'h00);
        scan_digit(8'h80, 8'hFF);
        scan_digit(8'h40, 8'hFF);
        scan_digit(8'h04, 8'hFF);
        scan_digit(8'h02, 8'h99);
        scan_digit(8'h01, 8'hC0);
        write_word(32'h0000_0000, 8'h04);
        scan_digit(8'h80, 8'hFF);
        scan_digit(8'h04, 8'h7F);
        scan_digit(8'h02, 8'hFF);
        scan_digit(8'h01, 8'hC0);

        // 5: multi-hot select
        check_eq("err_before", {31'd0, err}, 32'd0);
        select = 8'h81;
        tick();
        check_eq("multi_an", {24'd0, dig_an}, 32'h00);
        check_eq("multi_seg", {24'd0, seg}, 32'hFF);
        check_eq("multi_err", {31'd0, err}, 32'd1);
        scan_digit(8'h01, 8'hC0);
        check_eq("err_sticky", {31'd0, err}, 32'd1);

        // 6: disable while a write is pending
        write_word(32'h0000_0009, 8'h00);
        en = 1'b0;
        tick();
        check_eq("en0_ready", {31'd0, wr_ready}, 32'd1);
        check_eq("en0_an", {24'd0, dig_an}, 32'h00);
        check_eq("en0_seg", {24'd0, seg}, 32'hFF);
        en = 1'b1;
        tick();
        check_eq("en1_an", {24'd0, dig_an}, 32'h01);
        check_eq("en1_seg", {24'd0, seg}, 32'h90);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
